// File: rtl/main_memory_shadow.sv
// Single-port RAM with a write-protected ROM window and fixed 1-cycle response latency.
// Optional boot copy of the ROM image into RAM is enabled by defining SHADOW_COPY_EN.
module main_memory_shadow #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned ROM_BASE      = 0,
  parameter int unsigned ROM_SIZE      = 32768,
  parameter string       ROM_DATA_FILE = "Monitor.mem"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              rom_wp,
  output logic              wp_err,
  input  logic              err_clr,
  output logic              boot_done
);
  localparam logic [ADDR_W:0] LP_BASE_W = (ADDR_W+1)'(ROM_BASE);
  localparam logic [ADDR_W:0] LP_SIZE_W = (ADDR_W+1)'(ROM_SIZE);

  typedef enum logic {ST_COPY, ST_SERVE} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_wp_err;

  logic              w_hs;
  logic              w_prot;
  logic              w_ram_we;
  logic [ADDR_W:0]   w_win_off;
  logic              w_copy_done;
  logic              w_cp_vld;
  logic [ADDR_W-1:0] w_cp_addr;
  logic [DATA_W-1:0] w_cp_data;

  assign w_hs      = req_valid & req_ready;
  // Addresses below the base wrap to >= 2^ADDR_W, so one unsigned compare covers both bounds.
  assign w_win_off = {1'b0, req_addr} - LP_BASE_W;
  assign w_prot    = req_we & rom_wp & (w_win_off < LP_SIZE_W);
  assign w_ram_we  = w_hs & req_we & ~w_prot;

`ifdef SHADOW_COPY_EN
  localparam logic [ADDR_W-1:0] LP_BASE_A = ADDR_W'(ROM_BASE);
  localparam int unsigned       LP_RI_W   = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;

  logic [DATA_W-1:0] r_rom_img [0:ROM_SIZE-1];
  logic [ADDR_W:0]   r_idx;
  logic              r_cp_vld;
  logic [ADDR_W-1:0] r_cp_addr;
  logic [DATA_W-1:0] r_cp_data;

  // Stage 1 reads the image; stage 2 (the RAM write port) commits it one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_cp_vld  <= 1'b0;
      r_cp_addr <= '0;
      r_cp_data <= '0;
    end else begin
      r_cp_vld <= 1'b0;
      if (r_state == ST_COPY && r_idx < LP_SIZE_W) begin
        r_cp_data <= r_rom_img[r_idx[LP_RI_W-1:0]];
        r_cp_addr <= LP_BASE_A + r_idx[ADDR_W-1:0];
        r_cp_vld  <= 1'b1;
        r_idx     <= r_idx + 1'b1;
      end
    end
  end

  assign w_copy_done = (r_idx == LP_SIZE_W) && !r_cp_vld;
  assign w_cp_vld    = r_cp_vld;
  assign w_cp_addr   = r_cp_addr;
  assign w_cp_data   = r_cp_data;
`else
  assign w_copy_done = 1'b1;
  assign w_cp_vld    = 1'b0;
  assign w_cp_addr   = '0;
  assign w_cp_data   = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_COPY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_COPY && w_copy_done) w_state_nxt = ST_SERVE;
  end

  always_comb begin
    req_ready = 1'b0;
    boot_done = 1'b0;
    if (r_state == ST_SERVE) begin
      req_ready = 1'b1;
      boot_done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cp_vld)      r_mem[w_cp_addr] <= w_cp_data;
    else if (w_ram_we) r_mem[req_addr]  <= req_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wp_err    <= 1'b0;
    end else begin
      r_rsp_valid <= w_hs;
      if (w_hs) begin
        r_rsp_rdata <= r_mem[req_addr];
        r_rsp_err   <= w_prot;
      end
      if (w_hs & w_prot) r_wp_err <= 1'b1;
      else if (err_clr)  r_wp_err <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign wp_err    = r_wp_err;

endmodule

// File: tb/tb_main_memory_shadow.sv
// Randomised self-checking bench for main_memory_shadow against an array-based memory model.
// Builds with or without SHADOW_COPY_EN.
module tb_main_memory_shadow;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 16;
    localparam int ROM_BASE = 0;
    localparam int ROM_SIZE = 16;
`ifdef SHADOW_COPY_EN
    localparam int LP_BOOT  = ROM_SIZE + 1;
`else
    localparam int LP_BOOT  = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rom_wp = 1'b0;
    logic              wp_err;
    logic              err_clr = 1'b0;
    logic              boot_done;

    main_memory_shadow #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .ROM_BASE     (ROM_BASE),
        .ROM_SIZE     (ROM_SIZE),
        .ROM_DATA_FILE("")
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rom_wp    (rom_wp),
        .wp_err    (wp_err),
        .err_clr   (err_clr),
        .boot_done (boot_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: contents plus a flag for words whose value is defined.
    logic [DATA_W-1:0] m_mem   [0:(1<<ADDR_W)-1];
    bit                m_known [0:(1<<ADDR_W)-1];

    logic              e_valid = 1'b0;
    logic [DATA_W-1:0] e_rdata = '0;
    bit                e_known = 1'b1;
    logic              e_err   = 1'b0;
    logic              e_wperr = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [ADDR_W-1:0] a);
        return (int'(a) >= ROM_BASE) && (int'(a) < ROM_BASE + ROM_SIZE);
    endfunction

    task automatic check_outputs();
        check("req_ready", req_ready, 1);
        check("rsp_valid", rsp_valid, e_valid);
        if (e_known) check("rsp_rdata", rsp_rdata, e_rdata);
        check("rsp_err", rsp_err, e_err);
        check("wp_err", wp_err, e_wperr);
    endtask

    // One bus cycle: verify the response to the previous request, then issue a new one.
    task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic wp, input logic clr);
        bit prot;
        @(negedge clk);
        check_outputs();
        prot = v && we && wp && in_window(a);
        e_valid = v;
        if (v) begin
            e_rdata = m_mem[a];
            e_known = m_known[a];
            e_err   = prot;
            if (we && !prot) begin
                m_mem[a]   = d;
                m_known[a] = 1'b1;
            end
        end
        if (prot)     e_wperr = 1'b1;
        else if (clr) e_wperr = 1'b0;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rom_wp    = wp;
        err_clr   = clr;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_wp_err"}, wp_err, 0);
        check({tag, "_boot_done"}, boot_done, 0);
    endtask

    task automatic do_boot();
        req_valid = 1'b0;
        req_we    = 1'b0;
        rom_wp    = 1'b0;
        err_clr   = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        for (int k = 0; k <= LP_BOOT; k++) begin
            @(negedge clk);
            check("boot_ready", req_ready, (k >= LP_BOOT) ? 1 : 0);
            check("boot_done", boot_done, (k >= LP_BOOT) ? 1 : 0);
        end
        e_valid = 1'b0;
        e_rdata = '0;
        e_known = 1'b1;
        e_err   = 1'b0;
        e_wperr = 1'b0;
`ifdef SHADOW_COPY_EN
        for (int i = 0; i < ROM_SIZE; i++) begin
            m_mem[ROM_BASE + i]   = DATA_W'(8'h10 + i);
            m_known[ROM_BASE + i] = 1'b1;
        end
`endif
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return ADDR_W'($urandom_range(0, 31));
            1:       return ADDR_W'(16'h8000 + $urandom_range(0, 63));
            default: return ADDR_W'(16'hFFF0 + $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) m_known[i] = 1'b0;
`ifdef SHADOW_COPY_EN
        for (int i = 0; i < ROM_SIZE; i++) dut.r_rom_img[i] = DATA_W'(8'h10 + i);
`endif
        do_boot();

`ifdef SHADOW_COPY_EN
        // Interrupt the copy at idx 7 and confirm it restarts cleanly.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (7) @(negedge clk);
        check("midcopy_ready", req_ready, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("midcopy");
        do_boot();
`else
        for (int i = 0; i < ROM_SIZE; i++)
            step(1, 1, ADDR_W'(ROM_BASE + i), DATA_W'(8'h10 + i), 0, 0);
`endif

        for (int i = 0; i < ROM_SIZE; i++) step(1, 0, ADDR_W'(ROM_BASE + i), '0, 0, 0);

        // Write-protect, window edge, sticky error with simultaneous clear.
        step(1, 1, 16'h0005, 8'hAA, 1, 0);
        step(1, 0, 16'h0005, 8'h00, 0, 0);
        step(1, 1, 16'h000F, 8'hBB, 1, 1);
        step(0, 0, 16'h0000, 8'h00, 0, 1);
        step(1, 1, 16'h0010, 8'hCC, 1, 0);
        step(1, 0, 16'h0010, 8'h00, 0, 0);
        step(1, 1, 16'h0005, 8'hAA, 0, 0);
        step(1, 0, 16'h0005, 8'h00, 0, 0);

        // Read-first followed by read-after-write.
        step(1, 1, 16'h8000, 8'h00, 0, 0);
        step(1, 1, 16'h8000, 8'h55, 0, 0);
        step(1, 0, 16'h8000, 8'h00, 0, 0);

        // Streaming: back-to-back writes then 32 back-to-back reads.
        for (int i = 1; i < 32; i++) step(1, 1, ADDR_W'(16'h8000 + i), DATA_W'($urandom), 0, 0);
        for (int i = 0; i < 32; i++) step(1, 0, ADDR_W'(16'h8000 + i), '0, 0, 0);
        step(0, 0, '0, '0, 0, 0);

        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                 DATA_W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);

        // Reset while a response is in flight: it is dropped, RAM survives.
        step(1, 0, 16'h8001, '0, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("inflight_rsp_valid", rsp_valid, 0);
        check("inflight_ready", req_ready, 0);
        do_boot();
        for (int i = 0; i < 8; i++) step(1, 0, ADDR_W'(16'h8000 + i), '0, 0, 0);
        step(1, 0, 16'h0003, '0, 0, 0);
        step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
